csa_key_stream: RTL and testbench



---
 rtl/csa_pkg.sv | 18 +
 rtl/key_perm.sv | 27 ++
 rtl/csa_key_stream.sv | 114 +++++++++++
 tb/tb_csa_key_stream.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants, FSM encoding and helpers for the CSA key-stream reader.
package csa_pkg;

    localparam int CSA_KEY_BYTES = 56;
    localparam int CSA_KEY_SLOTS = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        STREAM = 2'd2
    } csa_state_t;

    // Per-slot whitening constant: the slot number replicated into every byte.
    function automatic logic [63:0] slot_xor(input logic [2:0] s);
        return {8{{5'b00000, s}}};
    endfunction

endpackage

// File: rtl/key_perm.sv
// CSA key-schedule bit permutation (combinational, 64 bits).
// Input bit j lands on output bit KEY_PERM_TBL[j]-1 (table is 1-based).
module key_perm (
    input  logic [63:0] din,
    output logic [63:0] dout
);

    localparam logic [6:0] KEY_PERM_TBL [64] = '{
        7'h12, 7'h24, 7'h09, 7'h07, 7'h2A, 7'h31, 7'h1D, 7'h15,
        7'h1C, 7'h36, 7'h3E, 7'h32, 7'h13, 7'h21, 7'h3B, 7'h40,
        7'h18, 7'h14, 7'h25, 7'h27, 7'h02, 7'h35, 7'h1B, 7'h01,
        7'h22, 7'h04, 7'h0D, 7'h0E, 7'h39, 7'h28, 7'h1A, 7'h29,
        7'h33, 7'h23, 7'h34, 7'h0C, 7'h16, 7'h30, 7'h1E, 7'h3A,
        7'h2D, 7'h1F, 7'h08, 7'h19, 7'h17, 7'h2F, 7'h3D, 7'h11,
        7'h3C, 7'h05, 7'h38, 7'h2B, 7'h0B, 7'h06, 7'h0A, 7'h2C,
        7'h20, 7'h3F, 7'h2E, 7'h0F, 7'h03, 7'h26, 7'h10, 7'h37
    };

    // Scatter every input bit to its permuted position.
    always_comb begin
        dout = '0;
        for (int j = 0; j < 64; j++) begin
            dout[6'(KEY_PERM_TBL[j] - 7'd1)] = din[j];
        end
    end

endmodule

// File: rtl/csa_key_stream.sv
// Sequential CSA key-schedule reader: expands one control word into the
// 56-byte round-key store (one permutation per cycle), then streams the
// store out one byte per handshake.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high; valid does not depend on ready, and the byte/index/last outputs
// hold steady while valid is high and ready is low.
module csa_key_stream
    import csa_pkg::*;
#(
    parameter bit DESCEND = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cw,
    input  logic        cw_valid,
    output logic        cw_ready,
    output logic [7:0]  key_byte,
    output logic [5:0]  key_index,
    output logic        key_last,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        busy
);

    localparam int         STORE_W   = CSA_KEY_BYTES * 8;
    localparam logic [2:0] STEP_INIT = 3'(CSA_KEY_SLOTS - 2);
    localparam logic [5:0] PTR_FIRST = DESCEND ? 6'(CSA_KEY_BYTES - 1) : 6'd0;
    localparam logic [5:0] PTR_LAST  = DESCEND ? 6'd0 : 6'(CSA_KEY_BYTES - 1);

    csa_state_t         state_q, state_d;
    logic [STORE_W-1:0] store_q, store_d;
    logic [63:0]        perm_q, perm_d;
    logic [2:0]         step_q, step_d;
    logic [5:0]         ptr_q, ptr_d;
    logic [63:0]        perm_next;

    key_perm u_key_perm (
        .din  (perm_q),
        .dout (perm_next)
    );

    // Next-state, store/pointer updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        perm_d    = perm_q;
        step_d    = step_q;
        ptr_d     = ptr_q;
        cw_ready  = 1'b0;
        key_valid = 1'b0;
        key_byte  = 8'h00;
        key_index = 6'd0;
        key_last  = 1'b0;
        busy      = 1'b1;

        case (state_q)
            IDLE: begin
                cw_ready = 1'b1;
                busy     = 1'b0;
                if (cw_valid) begin
                    store_d[6*64 +: 64] = cw ^ slot_xor(3'd6);
                    perm_d  = cw;
                    step_d  = STEP_INIT;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                perm_d = perm_next;
                store_d[{step_q, 6'b000000} +: 64] = perm_next ^ slot_xor(step_q);
                step_d = step_q - 3'd1;
                if (step_q == 3'd0) begin
                    ptr_d   = PTR_FIRST;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                key_valid = 1'b1;
                key_byte  = store_q[{ptr_q, 3'b000} +: 8];
                key_index = ptr_q;
                key_last  = (ptr_q == PTR_LAST);
                if (key_ready) begin
                    if (ptr_q == PTR_LAST) begin
                        state_d = IDLE;
                    end else if (DESCEND) begin
                        ptr_d = ptr_q - 6'd1;
                    end else begin
                        ptr_d = ptr_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            store_q <= '0;
            perm_q  <= '0;
            step_q  <= 3'd0;
            ptr_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            perm_q  <= perm_d;
            step_q  <= step_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_csa_key_stream.sv
// Self-checking bench for csa_key_stream: golden key schedule pushed to a
// queue per accepted cw, popped and compared on every output handshake.
module tb_csa_key_stream;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // descending (default) instance
    logic [63:0] cw = '0;
    logic        cw_valid = 1'b0;
    logic        cw_ready;
    logic [7:0]  key_byte;
    logic [5:0]  key_index;
    logic        key_last;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        busy;

    // ascending instance
    logic [63:0] cw_a = '0;
    logic        cw_valid_a = 1'b0;
    logic        cw_ready_a;
    logic [7:0]  key_byte_a;
    logic [5:0]  key_index_a;
    logic        key_last_a;
    logic        key_valid_a;
    logic        key_ready_a = 1'b0;
    logic        busy_a;

    csa_key_stream #(.DESCEND(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cw        (cw),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .key_byte  (key_byte),
        .key_index (key_index),
        .key_last  (key_last),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy)
    );

    csa_key_stream #(.DESCEND(1'b0)) dut_asc (
        .clk       (clk),
        .rst       (rst),
        .cw        (cw_a),
        .cw_valid  (cw_valid_a),
        .cw_ready  (cw_ready_a),
        .key_byte  (key_byte_a),
        .key_index (key_index_a),
        .key_last  (key_last_a),
        .key_valid (key_valid_a),
        .key_ready (key_ready_a),
        .busy      (busy_a)
    );

    // ---------------- golden model / scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [14:0] exp_q[$];   // {last, index[5:0], byte[7:0]}

    int perm_tbl [64] = '{
        18, 36,  9,  7, 42, 49, 29, 21,
        28, 54, 62, 50, 19, 33, 59, 64,
        24, 20, 37, 39,  2, 53, 27,  1,
        34,  4, 13, 14, 57, 40, 26, 41,
        51, 35, 52, 12, 22, 48, 30, 58,
        45, 31,  8, 25, 23, 47, 61, 17,
        60,  5, 56, 43, 11,  6, 10, 44,
        32, 63, 46, 15,  3, 38, 16, 55
    };

    // Output bit k is taken from the input bit whose table entry equals k+1.
    function automatic logic [63:0] model_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) begin
            for (int j = 0; j < 64; j++) begin
                if (perm_tbl[j] == k + 1) y[k] = x[j];
            end
        end
        return y;
    endfunction

    function automatic void push_golden(input logic [63:0] c, input bit descend);
        logic [7:0]  store [56];
        logic [63:0] k;
        int          i;
        k = c;
        for (int s = 6; s >= 0; s--) begin
            for (int b = 0; b < 8; b++) store[8*s+b] = k[8*b +: 8] ^ 8'(s);
            k = model_perm(k);
        end
        for (int n = 0; n < 56; n++) begin
            i = descend ? 55 - n : n;
            exp_q.push_back({1'(n == 55), 6'(i), store[i]});
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Present c and wait for acceptance; returns just after the accept edge.
    // With keep_valid set, cw_valid stays high carrying next_c afterwards.
    task automatic send_cw(input logic [63:0] c, input bit keep_valid,
                           input logic [63:0] next_c);
        int n;
        n = 0;
        @(negedge clk);
        cw = c;
        cw_valid = 1'b1;
        while (cw_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cw_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_cw_timeout: cw_ready=%b required 1", cw_ready);
        end
        @(posedge clk);
        #1;
        if (keep_valid) cw = next_c;
        else cw_valid = 1'b0;
    endtask

    // Consume the stream of the main instance, comparing against exp_q.
    // abort_at > 0 applies rst after that many bytes.
    task automatic scoreboard_drain(input bit random_ready, input int abort_at);
        int          cyc, got, stall;
        bit          done, first, prev_stall, aborted;
        logic [14:0] obs, prev_obs, exp_v;
        cyc = 0; got = 0; stall = 0;
        done = 0; first = 1; prev_stall = 0; aborted = 0;
        prev_obs = '0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!random_ready) begin
                key_ready = 1'b1;
            end else if (stall > 0) begin
                key_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 9) == 0) begin
                key_ready = 1'b0;
                stall = 9;
            end else begin
                key_ready = ($urandom_range(0, 9) > 3);
            end
            obs = {key_last, key_index, key_byte};
            checks++;
            if (cw_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_flags: cw_ready=%b busy=%b required 0/1 (cycle %0d)",
                         cw_ready, busy, cyc);
            end
            if (prev_stall) begin
                checks++;
                if (key_valid !== 1'b1 || obs !== prev_obs) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%b out=%h required 1/%h",
                             key_valid, obs, prev_obs);
                end
            end
            if (key_valid === 1'b1 && first) begin
                first = 0;
                checks++;
                if (cyc != 7) begin
                    failures++;
                    $display("FAIL first_latency: %0d cycles required 7", cyc);
                end
            end
            if (key_valid === 1'b1 && key_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_byte: index=%0d byte=%h with empty queue",
                             key_index, key_byte);
                    done = 1;
                end else begin
                    exp_v = exp_q.pop_front();
                    if (obs !== exp_v) begin
                        failures++;
                        $display("FAIL stream_byte: last/idx/byte=%b/%0d/%h required %b/%0d/%h",
                                 obs[14], obs[13:8], obs[7:0], exp_v[14], exp_v[13:8], exp_v[7:0]);
                    end
                end
                got++;
                if (key_last === 1'b1) done = 1;
                if (abort_at > 0 && got == abort_at) begin
                    done = 1;
                    aborted = 1;
                end
            end
            prev_stall = (key_valid === 1'b1) && (key_ready !== 1'b1);
            prev_obs = obs;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout: %0d bytes after %0d cycles", got, cyc);
        end
        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
            key_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            checks++;
            if (key_valid !== 1'b0 || cw_ready !== 1'b1 || busy !== 1'b0 ||
                key_index !== 6'd0 || key_byte !== 8'h00) begin
                failures++;
                $display("FAIL reset_abort: valid=%b cw_ready=%b busy=%b idx=%0d byte=%h required 0/1/0/0/00",
                         key_valid, cw_ready, busy, key_index, key_byte);
            end
            exp_q.delete();
        end else begin
            @(negedge clk);
            key_ready = 1'b0;
            checks++;
            if (cw_ready !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_return: cw_ready=%b busy=%b valid=%b required 1/0/0",
                         cw_ready, busy, key_valid);
            end
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL stream_length: %0d bytes missing required 0", exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cw_ready !== 1'b1 || key_valid !== 1'b0 || key_last !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: cw_ready=%b valid=%b last=%b busy=%b required 1/0/0/0",
                     cw_ready, key_valid, key_last, busy);
        end
        checks++;
        if (key_byte !== 8'h00 || key_index !== 6'd0) begin
            failures++;
            $display("FAIL reset_data: byte=%h idx=%0d required 00/0", key_byte, key_index);
        end
        checks++;
        if (cw_ready_a !== 1'b1 || key_valid_a !== 1'b0 || busy_a !== 1'b0 ||
            key_last_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_asc: cw_ready=%b valid=%b busy=%b last=%b required 1/0/0/0",
                     cw_ready_a, key_valid_a, busy_a, key_last_a);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_cw;
        push_golden(64'h0, 1'b1);
        send_cw(64'h0, 1'b0, 64'h0);
        scoreboard_drain(1'b0, 0);
    endtask

    task automatic test_all_ones;
        push_golden(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        send_cw(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0);
        scoreboard_drain(1'b0, 0);
    endtask

    task automatic test_backpressure;
        push_golden(64'h0123_4567_89AB_CDEF, 1'b1);
        send_cw(64'h0123_4567_89AB_CDEF, 1'b0, 64'h0);
        scoreboard_drain(1'b1, 0);
    endtask

    task automatic test_busy_reject;
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        push_golden(a, 1'b1);
        send_cw(a, 1'b1, b);
        scoreboard_drain(1'b0, 0);
        push_golden(b, 1'b1);
        @(posedge clk);
        #1;
        cw_valid = 1'b0;
        scoreboard_drain(1'b1, 0);
    endtask

    task automatic test_reset_mid_stream;
        push_golden(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        send_cw(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'h0);
        scoreboard_drain(1'b0, 20);
        push_golden(64'h1122_3344_5566_7788, 1'b1);
        send_cw(64'h1122_3344_5566_7788, 1'b0, 64'h0);
        scoreboard_drain(1'b0, 0);
    endtask

    task automatic test_ascending;
        int          cyc, got;
        bit          done, first;
        logic [14:0] obs, exp_v;
        cyc = 0; got = 0; done = 0; first = 1;
        push_golden(64'h0, 1'b0);
        @(negedge clk);
        cw_a = 64'h0;
        cw_valid_a = 1'b1;
        key_ready_a = 1'b1;
        checks++;
        if (cw_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL asc_accept: cw_ready=%b required 1", cw_ready_a);
        end
        @(posedge clk);
        #1;
        cw_valid_a = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (key_valid_a === 1'b1 && first) begin
                first = 0;
                checks++;
                if (cyc != 7) begin
                    failures++;
                    $display("FAIL asc_latency: %0d cycles required 7", cyc);
                end
            end
            if (key_valid_a === 1'b1) begin
                obs = {key_last_a, key_index_a, key_byte_a};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL asc_extra: idx=%0d with empty queue", key_index_a);
                    done = 1;
                end else begin
                    exp_v = exp_q.pop_front();
                    if (obs !== exp_v) begin
                        failures++;
                        $display("FAIL asc_byte: last/idx/byte=%b/%0d/%h required %b/%0d/%h",
                                 obs[14], obs[13:8], obs[7:0], exp_v[14], exp_v[13:8], exp_v[7:0]);
                    end
                end
                got++;
                if (key_last_a === 1'b1) done = 1;
            end
        end
        checks++;
        if (!done || got != 56 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL asc_length: %0d bytes, %0d left required 56/0", got, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        key_ready_a = 1'b0;
        checks++;
        if (cw_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL asc_idle: cw_ready=%b busy=%b required 1/0", cw_ready_a, busy_a);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_zero_cw();
        test_all_ones();
        test_backpressure();
        test_busy_reject();
        test_reset_mid_stream();
        test_ascending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
